// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared states and sizes for the FIFO round-robin arbiter
package fifo_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int NUM_IN_DEF = 4;
    localparam int PCNT_W     = 8;

    typedef enum logic [1:0] {
        ST_RST    = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_PAUSE  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational 4-input round-robin priority encoder
module rr_pick (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic [3:0] gnt_onehot,
    output logic [1:0] gnt_idx,
    output logic       any_req
);

    always_comb begin
        logic [1:0] w_idx;
        gnt_onehot = '0;
        gnt_idx    = '0;
        any_req    = |req;
        // Walk from the farthest offset to the nearest so the nearest requester wins.
        for (int k = 4; k >= 1; k--) begin
            w_idx = last + 2'(k);
            if (req[w_idx]) begin
                gnt_onehot        = '0;
                gnt_onehot[w_idx] = 1'b1;
                gnt_idx           = w_idx;
            end
        end
    end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// rtl/fifo_rr_arbiter.sv - merges four input FIFOs into one output FIFO, one word per cycle
module fifo_rr_arbiter
    import fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NUM_IN = NUM_IN_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     init,
    input  logic [NUM_IN-1:0]        in_empty,
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    output logic [NUM_IN-1:0]        pop,
    input  logic                     out_almost_full,
    output logic                     push,
    output logic [DATA_W-1:0]        out_data,
    output logic [1:0]               grant_id,
    output logic [1:0]               state_out,
    output logic [PCNT_W-1:0]        pause_count
);

    state_t              r_state;
    logic [1:0]          r_last;
    logic                r_push;
    logic [DATA_W-1:0]   r_out_data;
    logic [1:0]          r_grant_id;
    logic [PCNT_W-1:0]   r_pause_count;

    logic [NUM_IN-1:0]   w_req;
    logic [NUM_IN-1:0]   w_gnt;
    logic [1:0]          w_idx;
    logic                w_any;
    logic                w_pop_en;

    assign w_req = ~in_empty;

    rr_pick u_pick (
        .req        (w_req),
        .last       (r_last),
        .gnt_onehot (w_gnt),
        .gnt_idx    (w_idx),
        .any_req    (w_any)
    );

    // almost_full wins over data availability; the previously popped word still lands.
    assign w_pop_en = (r_state == ST_ACTIVE) && init && !reset && !out_almost_full && w_any;
    assign pop      = w_pop_en ? w_gnt : '0;

    assign push        = r_push;
    assign out_data    = r_out_data;
    assign grant_id    = r_grant_id;
    assign state_out   = r_state;
    assign pause_count = r_pause_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_RST;
            r_last        <= 2'd3;
            r_push        <= 1'b0;
            r_out_data    <= '0;
            r_grant_id    <= '0;
            r_pause_count <= '0;
        end else begin
            r_push <= w_pop_en;
            if (w_pop_en) begin
                r_out_data <= in_data[32'(w_idx)*DATA_W +: DATA_W];
                r_grant_id <= w_idx;
                r_last     <= w_idx;
            end
            if (init) begin
                if (r_state == ST_PAUSE && r_pause_count != '1)
                    r_pause_count <= r_pause_count + 1'b1;
                case (r_state)
                    ST_RST:    r_state <= ST_IDLE;
                    ST_IDLE:   if (out_almost_full) r_state <= ST_PAUSE;
                               else if (w_any)      r_state <= ST_ACTIVE;
                    ST_ACTIVE: if (out_almost_full) r_state <= ST_PAUSE;
                               else if (!w_any)     r_state <= ST_IDLE;
                    ST_PAUSE:  if (!out_almost_full)
                                   r_state <= w_any ? ST_ACTIVE : ST_IDLE;
                    default:   r_state <= ST_RST;
                endcase
            end
        end
    end

endmodule

// File: doc/fifo_rr_arbiter.md
Name: fifo_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that merges four input FIFOs into one shared output FIFO.
- Pops one word per cycle from the granted non-empty input and pushes it to the output.
- Stops popping while the output FIFO reports almost_full.
- Sits between the per-port ingress FIFOs and the shared egress FIFO, alongside the flow-control FSM.

Parameters:
- DATA_W, 8, width of one FIFO word.
- NUM_IN, 4, number of input FIFOs; fixed at 4 in this revision (grant_id is 2 bits).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- init  input  1  enable; low freezes state, pointer and counters, with no pops.
- in_empty  input  4  empty flag of each input FIFO; bit i belongs to input i.
- in_data  input  32  input FIFO read data, first-word-fall-through; word i = in_data[8i+7:8i].
- pop  output  4  one-hot read strobe to the input FIFOs (combinational).
- out_almost_full  input  1  almost_full flag of the output FIFO.
- push  output  1  write strobe to the output FIFO (registered).
- out_data  output  8  write data to the output FIFO (registered).
- grant_id  output  2  index of the last input served (registered).
- state_out  output  2  current state encoding (registered).
- pause_count  output  8  saturating count of cycles spent in PAUSE (registered).

Behaviour:
- Reset (synchronous, active-high, sampled on clk rising edge):
  - state = RST, last_grant = 3 (so input 0 is checked first), push = 0, out_data = 0, grant_id = 0, pause_count = 0.
  - pop is forced to 0 combinationally whenever reset = 1.
- States and encodings: RST = 0, IDLE = 1, ACTIVE = 2, PAUSE = 3. Transitions occur only when init = 1:
  - RST -> IDLE.
  - IDLE -> PAUSE if out_almost_full; else -> ACTIVE if any in_empty bit is 0; else stay in IDLE.
  - ACTIVE -> PAUSE if out_almost_full; else -> IDLE if all inputs are empty; else stay in ACTIVE.
  - PAUSE -> ACTIVE when out_almost_full = 0 and any input is non-empty; -> IDLE when out_almost_full = 0 and all inputs are empty; else stay in PAUSE.
- Grant selection:
  - Candidates are the inputs with in_empty = 0.
  - Search order is last_grant+1, +2, +3, +4, all modulo 4; the first candidate found wins.
  - Round robin is per word: the grant rotates after every word, so no input can hold the grant.
- Pop condition:
  - pop[g] = 1 only when all of these hold: state == ACTIVE, init = 1, reset = 0, out_almost_full = 0, in_empty[g] = 0.
  - At most one pop bit is high in any cycle.
- Pipeline: on the edge that ends a pop cycle:
  - push <= 1, out_data <= in_data word g, grant_id <= g, last_grant <= g.
  - This gives one cycle of latency from pop to push.
  - If there is no pop, push <= 0 and out_data holds its value.
- Flag priority in the same cycle: out_almost_full dominates data availability. No pop is issued; the word registered in the previous cycle is still pushed, and the output FIFO's almost_full margin absorbs it.
- Empty inputs: an input whose in_empty = 1 is never popped, whatever the pointer position.
- Counter: pause_count increments by 1 for each cycle with state == PAUSE and init = 1, and saturates at 255. Only reset clears it.
- init = 0:
  - state, last_grant and pause_count hold their values, and pop = 0.
  - push <= 0 on the next edge; a word popped in the previous cycle is still pushed on that edge.
- Reset mid-transfer: an in-flight word is dropped (push is cleared at the reset edge). Input FIFO contents are not affected.

Decomposition:
- Shared package (fifo_pkg):
  - State encodings RST, IDLE, ACTIVE, PAUSE.
  - DATA_W and NUM_IN defaults.
  - Width constant for pause_count.
- Sub-module rr_pick:
  - Combinational 4-input round-robin priority encoder.
  - Inputs: req[3:0] and last[1:0].
  - Outputs: gnt_onehot[3:0], gnt_idx[1:0] and any_req.
  - It is reusable by other arbiters in the switch.

Test Plan:
- Single source: reset, init = 1, input 2 holds 0xA1 then 0xA2, all other inputs empty.
  - Required: IDLE -> ACTIVE; pop = 0100 in two consecutive cycles.
  - Required: push with out_data 0xA1, then 0xA2, each one cycle after its pop; grant_id = 2.
  - Required: return to IDLE once in_empty[2] = 1.
- Fairness: all four inputs non-empty, each holding 3 words, out_almost_full = 0.
  - Required: grant sequence 0,1,2,3,0,1,2,3,0,1,2,3 with no idle cycles; 12 pushes in total.
- Skip empty: inputs 1 and 3 are empty, last_grant = 0.
  - Required: grant order 2, 0, 2, 0, …; pop[1] and pop[3] never assert.
- Backpressure: out_almost_full rises while input 0 is mid-stream.
  - Required: pop = 0 in that same cycle; the one word already popped is still pushed.
  - Required: state goes to PAUSE.
  - Required: after 5 cycles in PAUSE, pause_count = 5; when almost_full falls, state returns to ACTIVE and the rotation resumes from last_grant+1.
- Freeze and reset: drop init to 0 during ACTIVE.
  - Required: pop = 0, push low from the next edge, state held.
  - Then assert reset for one cycle. Required: state = RST, push = 0, pause_count = 0, and the first grant after reset goes to input 0.
- Saturation: hold out_almost_full = 1 for 300 cycles.
  - Required: pause_count stops at 255 and never wraps; no pop during this time.
